// File: rtl/memory_unit_pkg.sv
// Shared definitions for the memory pipeline stage: opcode tags, instruction bit fields,
// writeback-address selects and the access FSM state type.
package cpu_pkg;

  localparam logic [6:0] OPCODE_NOP  = 7'b0100000;
  localparam logic [1:0] MEM_OP_TAG  = 2'b11;    // opcode[6:5] for STR/LDR
  localparam logic [3:0] LDR_LIT_TAG = 4'b1000;  // opcode[6:3] for LDR literal

  localparam int INSTR_L = 20;
  localparam int INSTR_W = 21;
  localparam int INSTR_P = 24;

  localparam logic [1:0] SEL_W_RN = 2'b10;
  localparam logic [1:0] SEL_W_RD = 2'b00;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

  function automatic logic is_ldr_lit(input logic [6:0] op);
    return op[6:3] == LDR_LIT_TAG;
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op[6:5] == MEM_OP_TAG) || is_ldr_lit(op);
  endfunction

  // Base-register writeback happens on write-back (W) or post-indexed (P=0) memory ops.
  function automatic logic [1:0] sel_w_addr1(input logic [6:0] op, input logic [31:0] instr);
    return (is_mem_op(op) && (instr[INSTR_W] || !instr[INSTR_P])) ? SEL_W_RN : SEL_W_RD;
  endfunction

endpackage

// File: rtl/memory_unit_if.sv
// Data-memory request/acknowledge bus: the stage is master, the memory is slave.
// The request is held with stable attributes until acknowledged.
interface memory_unit_if #(
  parameter int ADDR_W = 32
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/memory_unit_pipeline.sv
// Memory-stage register: captures execute-stage results on adv_i (NOP on flush), else holds.
// One-cycle latency; holding is the only backpressure response.
module memory_pipeline_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [6:0]  opcode_i,
  input  logic [3:0]  rn_i,
  input  logic [3:0]  rd_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [3:0]  rn_o,
  output logic [3:0]  rd_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] store_data_o,
  output logic [1:0]  sel_w_addr1_o
);

  logic [31:0] instr_q,      instr_d;
  logic [6:0]  opcode_q,     opcode_d;
  logic [3:0]  rn_q,         rn_d;
  logic [3:0]  rd_q,         rd_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] store_data_q, store_data_d;
  logic [1:0]  sel_q,        sel_d;

  always_comb begin
    instr_d      = instr_q;
    opcode_d     = opcode_q;
    rn_d         = rn_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    sel_d        = sel_q;
    if (adv_i) begin
      if (flush_i) begin
        instr_d      = '0;
        opcode_d     = OPCODE_NOP;
        rn_d         = '0;
        rd_d         = '0;
        alu_result_d = '0;
        store_data_d = '0;
        sel_d        = SEL_W_RD;
      end else begin
        instr_d      = instr_i;
        opcode_d     = opcode_i;
        rn_d         = rn_i;
        rd_d         = rd_i;
        alu_result_d = alu_result_i;
        store_data_d = store_data_i;
        sel_d        = sel_w_addr1(opcode_i, instr_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q      <= '0;
      opcode_q     <= OPCODE_NOP;
      rn_q         <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      store_data_q <= '0;
      sel_q        <= SEL_W_RD;
    end else begin
      instr_q      <= instr_d;
      opcode_q     <= opcode_d;
      rn_q         <= rn_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      sel_q        <= sel_d;
    end
  end

  assign instr_o       = instr_q;
  assign opcode_o      = opcode_q;
  assign rn_o          = rn_q;
  assign rd_o          = rd_q;
  assign alu_result_o  = alu_result_q;
  assign store_data_o  = store_data_q;
  assign sel_w_addr1_o = sel_q;

endmodule

// File: rtl/memory_unit.sv
// Memory pipeline stage: stage register plus the data-memory load/store handshake FSM.
// Non-memory ops take 1 cycle, memory ops 1 + cycles-to-ack; stall_mem holds upstream meanwhile.
module memory_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_in,
  input  logic [6:0]           opcode_in,
  input  logic [3:0]           rn_in,
  input  logic [3:0]           rd_in,
  input  logic [31:0]          alu_result_in,
  input  logic [31:0]          store_data_in,
  input  logic                 branch_in,
  input  logic                 sel_stall,
  memory_unit_if.master        dmem,
  output logic [6:0]           opcode_memory,
  output logic [3:0]           rn_memory,
  output logic [3:0]           rd_memory,
  output logic [1:0]           sel_w_addr1_memory,
  output logic [31:0]          instr_output,
  output logic [31:0]          alu_result_out,
  output logic [31:0]          load_data_out,
  output logic                 stall_mem,
  output logic                 mem_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  mem_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [31:0]       load_data_q;
  logic              mem_error_q;
  logic [31:0]       store_data_q;
  logic              adv;
  logic              is_load;

  assign stall_mem = (state_q == ACCESS);
  assign adv       = !sel_stall && !stall_mem;

  memory_pipeline_unit u_stage (
    .clk           (clk),
    .rst_n         (rst_n),
    .adv_i         (adv),
    .flush_i       (branch_in),
    .instr_i       (instr_in),
    .opcode_i      (opcode_in),
    .rn_i          (rn_in),
    .rd_i          (rd_in),
    .alu_result_i  (alu_result_in),
    .store_data_i  (store_data_in),
    .instr_o       (instr_output),
    .opcode_o      (opcode_memory),
    .rn_o          (rn_memory),
    .rd_o          (rd_memory),
    .alu_result_o  (alu_result_out),
    .store_data_o  (store_data_q),
    .sel_w_addr1_o (sel_w_addr1_memory)
  );

  assign is_load = instr_output[INSTR_L] || is_ldr_lit(opcode_memory);
  assign cnt_inc = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_data_q <= '0;
      mem_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (adv && !branch_in && is_mem_op(opcode_in)) begin
            state_q <= ACCESS;
            cnt_q   <= '0;
          end
        end
        ACCESS: begin
          // An ack on the final counted cycle still wins over the timeout.
          if (dmem.dmem_ack) begin
            state_q <= IDLE;
            if (is_load) begin
              load_data_q <= dmem.dmem_rdata;
            end
          end else if (cnt_inc == CNT_LIMIT) begin
            state_q     <= IDLE;
            cnt_q       <= cnt_inc;
            mem_error_q <= 1'b1;
            load_data_q <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = (state_q == ACCESS);
  assign dmem.dmem_we    = (state_q == ACCESS) && !is_load;
  assign dmem.dmem_addr  = alu_result_out[ADDR_W-1:0];
  assign dmem.dmem_wdata = store_data_q;

  assign load_data_out = load_data_q;
  assign mem_error     = mem_error_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed and randomized checks of the memory stage against a transaction-level model.
module tb_memory_unit;
  import cpu_pkg::*;

  localparam int TO = 16;
  localparam logic [6:0] NOP = 7'b0100000;
  localparam logic [6:0] ALU_OP = 7'b0001000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in, alu_result_in, store_data_in;
  logic [6:0]  opcode_in;
  logic [3:0]  rn_in, rd_in;
  logic        branch_in, sel_stall;
  logic [6:0]  opcode_memory;
  logic [3:0]  rn_memory, rd_memory;
  logic [1:0]  sel_w_addr1_memory;
  logic [31:0] instr_output, alu_result_out, load_data_out;
  logic        stall_mem, mem_error;

  int errors = 0;
  int checks = 0;

  logic [6:0]  exp_op;
  logic [31:0] exp_alu;
  logic [31:0] exp_load;
  logic        exp_err;

  memory_unit_if #(.ADDR_W(32)) dmem_bus ();

  always #5 clk = ~clk;

  memory_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .instr_in           (instr_in),
    .opcode_in          (opcode_in),
    .rn_in              (rn_in),
    .rd_in              (rd_in),
    .alu_result_in      (alu_result_in),
    .store_data_in      (store_data_in),
    .branch_in          (branch_in),
    .sel_stall          (sel_stall),
    .dmem               (dmem_bus),
    .opcode_memory      (opcode_memory),
    .rn_memory          (rn_memory),
    .rd_memory          (rd_memory),
    .sel_w_addr1_memory (sel_w_addr1_memory),
    .instr_output       (instr_output),
    .alu_result_out     (alu_result_out),
    .load_data_out      (load_data_out),
    .stall_mem          (stall_mem),
    .mem_error          (mem_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from an idle stage and follow it until it leaves the stage.
  // dly = ACCESS cycle in which ack arrives (1 = same cycle), 0 = never (timeout).
  task automatic run_op(input logic [6:0] op, input logic [31:0] ins, input logic [3:0] rn,
                        input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                        input logic br, input int dly, input logic [31:0] rdata,
                        input logic br_mid, input logic stall_at_ack);
    logic       mem, ld;
    logic [1:0] sel;
    mem = !br && ((op[6:5] == 2'b11) || (op[6:3] == 4'b1000));
    ld  = ins[20] || (op[6:3] == 4'b1000);
    sel = (mem && (ins[21] || !ins[24])) ? 2'b10 : 2'b00;
    opcode_in = op; instr_in = ins; rn_in = rn; rd_in = rd;
    alu_result_in = alu; store_data_in = sd; branch_in = br; sel_stall = 1'b0;
    tick();
    exp_op  = br ? NOP : op;
    exp_alu = br ? 32'h0 : alu;
    chk("opcode", 32'(opcode_memory), 32'(exp_op));
    chk("rn", 32'(rn_memory), br ? 32'h0 : 32'(rn));
    chk("rd", 32'(rd_memory), br ? 32'h0 : 32'(rd));
    chk("instr", instr_output, br ? 32'h0 : ins);
    chk("alu", alu_result_out, exp_alu);
    chk("sel_w", 32'(sel_w_addr1_memory), 32'(sel));
    chk("stall_capture", 32'(stall_mem), 32'(mem));
    chk("req_capture", 32'(dmem_bus.dmem_req), 32'(mem));
    if (mem) begin
      chk("we", 32'(dmem_bus.dmem_we), 32'(!ld));
      chk("addr", dmem_bus.dmem_addr, alu);
      chk("wdata", dmem_bus.dmem_wdata, sd);
      // Upstream keeps changing while the access is outstanding; the stage must ignore it.
      opcode_in = 7'($urandom); instr_in = $urandom; alu_result_in = $urandom;
      rn_in = 4'($urandom); branch_in = br_mid;
      if (dly == 0) begin
        for (int c = 1; c < TO; c++) begin
          tick();
          chk("req_wait", 32'(dmem_bus.dmem_req), 32'h1);
        end
        tick();
        chk("req_timeout", 32'(dmem_bus.dmem_req), 32'h0);
        exp_err  = 1'b1;
        exp_load = 32'h0;
      end else begin
        for (int c = 1; c < dly; c++) begin
          tick();
          chk("req_wait", 32'(dmem_bus.dmem_req), 32'h1);
          chk("addr_stable", dmem_bus.dmem_addr, alu);
        end
        dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = rdata; sel_stall = stall_at_ack;
        tick();
        dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = $urandom;
        chk("req_done", 32'(dmem_bus.dmem_req), 32'h0);
        if (ld) exp_load = rdata;
        if (stall_at_ack) begin
          tick();
          chk("req_held", 32'(dmem_bus.dmem_req), 32'h0);
          chk("opcode_held", 32'(opcode_memory), 32'(exp_op));
          sel_stall = 1'b0;
        end
      end
      chk("opcode_occupancy", 32'(opcode_memory), 32'(exp_op));
      chk("stall_done", 32'(stall_mem), 32'h0);
    end
    chk("load_data", load_data_out, exp_load);
    chk("mem_error", 32'(mem_error), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    opcode_in = ALU_OP; instr_in = '0; rn_in = '0; rd_in = '0; alu_result_in = '0;
    store_data_in = '0; branch_in = 1'b0; sel_stall = 1'b0;
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
    exp_load = '0; exp_err = 1'b0; exp_op = NOP; exp_alu = '0;

    // Reset held for two cycles
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_opcode", 32'(opcode_memory), 32'(NOP));
    chk("rst_stall", 32'(stall_mem), 32'h0);
    chk("rst_req", 32'(dmem_bus.dmem_req), 32'h0);
    chk("rst_err", 32'(mem_error), 32'h0);
    chk("rst_alu", alu_result_out, 32'h0);
    chk("rst_load", load_data_out, 32'h0);
    rst_n = 1'b1;

    // ALU op passes in one cycle without stalling
    run_op(ALU_OP, 32'h0, 4'd1, 4'd2, 32'h1234, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1'b0);
    run_op(ALU_OP, 32'h0, 4'd3, 4'd4, 32'h5678, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1'b0);

    // Ack while idle is ignored
    opcode_in = ALU_OP; alu_result_in = 32'h9; dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hFFFF0000;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    exp_op = ALU_OP; exp_alu = 32'h9;
    chk("idle_ack_load", load_data_out, exp_load);
    chk("idle_ack_req", 32'(dmem_bus.dmem_req), 32'h0);

    // LDR at 0x40, ack in the third access cycle, next op captured right after
    run_op(7'b1100001, 32'h0110_0000, 4'd2, 4'd7, 32'h40, 32'h0, 1'b0, 3, 32'hDEADBEEF, 1'b0, 1'b0);
    run_op(ALU_OP, 32'h0, 4'd0, 4'd1, 32'h77, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1'b0);

    // STR with writeback to Rn=5
    run_op(7'b1100000, 32'h0120_0000, 4'd5, 4'd6, 32'h100, 32'hA5A5A5A5, 1'b0, 2, 32'h1111, 1'b0, 1'b0);

    // LDR literal, same-cycle ack coinciding with downstream stall
    run_op(7'b1000010, 32'h0100_0000, 4'd1, 4'd9, 32'h200, 32'h0, 1'b0, 1, 32'hCAFE0001, 1'b0, 1'b1);

    // Branch raised mid-access: the load completes, the next capture is a NOP
    run_op(7'b1110000, 32'h0110_0000, 4'd4, 4'd3, 32'h300, 32'h0, 1'b0, 2, 32'h13572468, 1'b1, 1'b0);
    tick();
    chk("flush_opcode", 32'(opcode_memory), 32'(NOP));
    chk("flush_rn", 32'(rn_memory), 32'h0);
    chk("flush_stall", 32'(stall_mem), 32'h0);
    exp_op = NOP; exp_alu = 32'h0;

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      case (r[1:0])
        2'd0:    op = {2'b00, r[6:2]};
        2'd1:    op = {2'b11, r[6:2]};
        2'd2:    op = {4'b1000, r[4:2]};
        default: op = {2'b01, r[6:2]};
      endcase
      if (r[9:8] == 2'b00) begin
        sel_stall = 1'b1; opcode_in = 7'($urandom); alu_result_in = $urandom; branch_in = r[10];
        tick();
        chk("hold_opcode", 32'(opcode_memory), 32'(exp_op));
        chk("hold_alu", alu_result_out, exp_alu);
        chk("hold_stall", 32'(stall_mem), 32'h0);
        sel_stall = 1'b0;
      end
      run_op(op, $urandom, 4'($urandom), 4'($urandom), $urandom, $urandom,
             (r[13:11] == 3'b000), int'($urandom_range(1, 5)), $urandom, r[14], r[15]);
    end

    // Timeout with no ack; error is sticky afterwards
    run_op(7'b1100000, 32'h0100_0000, 4'd8, 4'd8, 32'h400, 32'h55AA55AA, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    run_op(ALU_OP, 32'h0, 4'd1, 4'd1, 32'h44, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1'b0);
    run_op(7'b1100011, 32'h0110_0000, 4'd2, 4'd2, 32'h48, 32'h0, 1'b0, 2, 32'h0BADF00D, 1'b0, 1'b0);

    // Reset during an outstanding access abandons it
    opcode_in = 7'b1100001; instr_in = 32'h0110_0000; alu_result_in = 32'h80; branch_in = 1'b0;
    tick();
    chk("pre_rst_req", 32'(dmem_bus.dmem_req), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req", 32'(dmem_bus.dmem_req), 32'h0);
    chk("mid_rst_opcode", 32'(opcode_memory), 32'(NOP));
    chk("mid_rst_err", 32'(mem_error), 32'h0);
    rst_n = 1'b1;
    opcode_in = ALU_OP;
    tick();
    chk("post_rst_req", 32'(dmem_bus.dmem_req), 32'h0);
    chk("post_rst_stall", 32'(stall_mem), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
